// File: rtl/mem_responder_if.sv
// Request/response channel between the load/store unit and the memory responder.
// Both channels use a valid/ready handshake.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word RAM behind valid/ready request and response channels.
// Fixed access latency, one outstanding transaction.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        aerr_q, aerr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];
  logic        req_err;
  logic        mem_we;

  assign req_err = (bus.req_addr[1:0] != 2'b00)
                || ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    aerr_d  = aerr_q;
    valid_d = valid_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_wr;
          idx_d   = bus.req_addr[AW+1:2];
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          aerr_d  = req_err;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          valid_d = 1'b1;
          err_d   = aerr_q;
          rdata_d = (wr_q || aerr_q) ? 32'd0 : mem[idx_q];
          mem_we  = wr_q && !aerr_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          rdata_d = 32'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      aerr_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      aerr_q  <= aerr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; writes only happen on the commit edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
